// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, operand and
// destination encodings, phase state enum and per-phase strobe bundles.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADC    = 4'd0;
  localparam logic [3:0] OP_SBC    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_ORA    = 4'd3;
  localparam logic [3:0] OP_EOR    = 4'd4;
  localparam logic [3:0] OP_SR     = 4'd5;
  localparam logic [3:0] OP_CMP    = 4'd6;
  localparam logic [3:0] OP_PASS   = 4'd7;
  localparam logic [3:0] OP_ADRADD = 4'd8;

  typedef enum logic [1:0] {
    BSRC_DB  = 2'd0,
    BSRC_NDB = 2'd1,
    BSRC_Z   = 2'd2,
    BSRC_ADL = 2'd3
  } bsrc_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_AC   = 2'd1,
    DST_ADL  = 2'd2,
    DST_SB   = 2'd3
  } dst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OPER = 2'd2,
    ST_WRBK = 2'd3
  } state_e;

  // Input-latch strobes plus the accumulator-to-SB transfer used in LOAD.
  typedef struct packed {
    logic sb_add;
    logic ndb_add;
    logic db_add;
    logic z_add;
    logic adl_add;
    logic ac_sb;
  } load_strb_t;

  typedef struct packed {
    logic ands;
    logic eors;
    logic ors;
    logic srs;
    logic sums;
  } op_strb_t;

  typedef struct packed {
    logic add_sb06;
    logic add_sb7;
    logic add_adl;
    logic sb_ac;
  } xfer_strb_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_ADRADD);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the latched operation into the strobe sets used
// in each phase, plus carry/decimal controls and flag-update enables.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int DEC_EN = 1
) (
  input  logic [3:0] i_op,
  input  bsrc_e      i_bsrc,
  input  dst_e       i_dst,
  input  logic       i_cin,
  input  logic       i_dmode,
  output load_strb_t o_load,
  output op_strb_t   o_oper,
  output xfer_strb_t o_wrbk,
  output logic       o_carry,
  output logic       o_daa,
  output logic       o_dsa,
  output logic       o_upd_c,
  output logic       o_upd_v,
  output logic       o_illegal
);

  bsrc_e w_bsel;
  logic  w_legal;

  // Per-phase strobe masks derived from the latched operation.
  always_comb begin
    o_load    = '0;
    o_oper    = '0;
    o_wrbk    = '0;
    o_upd_c   = 1'b0;
    o_upd_v   = 1'b0;
    w_legal   = op_is_legal(i_op);
    o_illegal = !w_legal;
    o_carry   = (i_op == OP_CMP) ? 1'b1 : i_cin;
    o_daa     = (DEC_EN != 0) && i_dmode && (i_op == OP_ADC);
    o_dsa     = (DEC_EN != 0) && i_dmode && (i_op == OP_SBC);

    // Subtract-type ops always take the inverted bus; address add always ADL.
    w_bsel = i_bsrc;
    if ((i_op == OP_SBC) || (i_op == OP_CMP)) begin
      w_bsel = BSRC_NDB;
    end else if (i_op == OP_ADRADD) begin
      w_bsel = BSRC_ADL;
    end

    // Illegal ops still load the latches but never move the accumulator.
    o_load.ac_sb  = w_legal;
    // Shift right feeds zero into the A side instead of SB.
    o_load.sb_add = (i_op != OP_SR);
    case (w_bsel)
      BSRC_DB:  o_load.db_add  = 1'b1;
      BSRC_NDB: o_load.ndb_add = 1'b1;
      BSRC_Z:   o_load.z_add   = 1'b1;
      default:  o_load.adl_add = 1'b1;
    endcase
    if (i_op == OP_SR) begin
      o_load.z_add = 1'b1;
    end

    case (i_op)
      OP_ADC, OP_SBC: begin
        o_oper.sums = 1'b1;
        o_upd_c     = 1'b1;
        o_upd_v     = 1'b1;
      end
      OP_CMP, OP_PASS, OP_ADRADD: begin
        o_oper.sums = 1'b1;
        o_upd_c     = 1'b1;
      end
      OP_AND: o_oper.ands = 1'b1;
      OP_ORA: o_oper.ors  = 1'b1;
      OP_EOR: o_oper.eors = 1'b1;
      OP_SR: begin
        o_oper.srs = 1'b1;
        o_upd_c    = 1'b1;
      end
      default: ;
    endcase

    // Compare only sets flags; its result is never written anywhere.
    if (w_legal && (i_op != OP_CMP)) begin
      case (i_dst)
        DST_AC: begin
          o_wrbk.add_sb06 = 1'b1;
          o_wrbk.add_sb7  = 1'b1;
          o_wrbk.sb_ac    = 1'b1;
        end
        DST_ADL: o_wrbk.add_adl = 1'b1;
        DST_SB: begin
          o_wrbk.add_sb06 = 1'b1;
          o_wrbk.add_sb7  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Three-phase ALU operation sequencer: load operands, operate, write back.
// Latches the request on accept, drives ALU control strobes per phase and
// captures the ALU carry/overflow into the flag registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for REQ, all strobes inactive
//   ST_LOAD | A/B input latches loaded from SB and selected B source
//   ST_OPER | ALU operation selected; flags captured at the end
//   ST_WRBK | result transferred to destination, DONE pulse, may re-accept
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEC_EN = 1
) (
  input  logic       PHI0,
  input  logic       n_RES,
  input  logic       REQ,
  input  logic [3:0] OP,
  input  logic [1:0] BSRC,
  input  logic [1:0] DST,
  input  logic       CIN,
  input  logic       DMODE,
  input  logic       ACR,
  input  logic       AVR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       C_OUT,
  output logic       V_OUT,
  output logic       SB_ADD,
  output logic       NDB_ADD,
  output logic       DB_ADD,
  output logic       Z_ADD,
  output logic       ADL_ADD,
  output logic       ANDS,
  output logic       EORS,
  output logic       ORS,
  output logic       SRS,
  output logic       SUMS,
  output logic       ADD_SB06,
  output logic       ADD_SB7,
  output logic       ADD_ADL,
  output logic       SB_AC,
  output logic       AC_SB,
  output logic       n_ACIN,
  output logic       n_DAA,
  output logic       n_DSA
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_op;
  bsrc_e      r_bsrc;
  dst_e       r_dst;
  logic       r_cin;
  logic       r_dmode;
  logic       r_c;
  logic       r_v;

  logic       w_accept;
  load_strb_t w_load;
  op_strb_t   w_oper;
  xfer_strb_t w_wrbk;
  logic       w_carry;
  logic       w_daa;
  logic       w_dsa;
  logic       w_upd_c;
  logic       w_upd_v;
  logic       w_illegal;

  assign w_accept = REQ && ((r_state == ST_IDLE) || (r_state == ST_WRBK));

  alu_op_decode #(
    .DEC_EN (DEC_EN)
  ) u_decode (
    .i_op      (r_op),
    .i_bsrc    (r_bsrc),
    .i_dst     (r_dst),
    .i_cin     (r_cin),
    .i_dmode   (r_dmode),
    .o_load    (w_load),
    .o_oper    (w_oper),
    .o_wrbk    (w_wrbk),
    .o_carry   (w_carry),
    .o_daa     (w_daa),
    .o_dsa     (w_dsa),
    .o_upd_c   (w_upd_c),
    .o_upd_v   (w_upd_v),
    .o_illegal (w_illegal)
  );

  // Phase state register.
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase sequencing; WRBK chains straight into LOAD on a pending request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (REQ) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_OPER;
      ST_OPER: w_state_nxt = ST_WRBK;
      ST_WRBK: w_state_nxt = REQ ? ST_LOAD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are held for the whole operation so mid-op input changes are ignored.
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      r_op    <= OP_ADC;
      r_bsrc  <= BSRC_DB;
      r_dst   <= DST_NONE;
      r_cin   <= 1'b0;
      r_dmode <= 1'b0;
    end else if (w_accept) begin
      r_op    <= OP;
      r_bsrc  <= bsrc_e'(BSRC);
      r_dst   <= dst_e'(DST);
      r_cin   <= CIN;
      r_dmode <= DMODE;
    end
  end

  // Carry/overflow capture on the edge that leaves OPER.
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (r_state == ST_OPER) begin
      if (w_upd_c) r_c <= ACR;
      if (w_upd_v) r_v <= AVR;
    end
  end

  assign BUSY  = (r_state != ST_IDLE);
  assign C_OUT = r_c;
  assign V_OUT = r_v;

  // Strobe outputs gated by the current phase; decimal lines span OPER and WRBK.
  always_comb begin
    SB_ADD   = 1'b0;
    NDB_ADD  = 1'b0;
    DB_ADD   = 1'b0;
    Z_ADD    = 1'b0;
    ADL_ADD  = 1'b0;
    AC_SB    = 1'b0;
    ANDS     = 1'b0;
    EORS     = 1'b0;
    ORS      = 1'b0;
    SRS      = 1'b0;
    SUMS     = 1'b0;
    ADD_SB06 = 1'b0;
    ADD_SB7  = 1'b0;
    ADD_ADL  = 1'b0;
    SB_AC    = 1'b0;
    n_ACIN   = 1'b1;
    n_DAA    = 1'b1;
    n_DSA    = 1'b1;
    DONE     = 1'b0;
    ERR      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        SB_ADD  = w_load.sb_add;
        NDB_ADD = w_load.ndb_add;
        DB_ADD  = w_load.db_add;
        Z_ADD   = w_load.z_add;
        ADL_ADD = w_load.adl_add;
        AC_SB   = w_load.ac_sb;
      end
      ST_OPER: begin
        ANDS  = w_oper.ands;
        EORS  = w_oper.eors;
        ORS   = w_oper.ors;
        SRS   = w_oper.srs;
        SUMS  = w_oper.sums;
        if (!w_illegal) n_ACIN = ~w_carry;
        n_DAA = ~w_daa;
        n_DSA = ~w_dsa;
      end
      ST_WRBK: begin
        ADD_SB06 = w_wrbk.add_sb06;
        ADD_SB7  = w_wrbk.add_sb7;
        ADD_ADL  = w_wrbk.add_adl;
        SB_AC    = w_wrbk.sb_ac;
        n_DAA    = ~w_daa;
        n_DSA    = ~w_dsa;
        DONE     = 1'b1;
        ERR      = w_illegal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a phase-level reference model checked every
// cycle against two instances (decimal enabled and disabled), plus directed
// literal checks on the key scenarios.
module tb_alu_op_sequencer;

  localparam int I_BUSY = 22, I_DONE = 21, I_ERR = 20, I_C = 19, I_V = 18;
  localparam int I_SBADD = 17, I_NDB = 16, I_DB = 15, I_Z = 14, I_ADL = 13;
  localparam int I_ANDS = 12, I_EORS = 11, I_ORS = 10, I_SRS = 9, I_SUMS = 8;
  localparam int I_SB06 = 7, I_SB7 = 6, I_ADDADL = 5, I_SBAC = 4, I_ACSB = 3;
  localparam int I_NACIN = 2, I_NDAA = 1, I_NDSA = 0;

  logic       PHI0 = 1'b0;
  logic       n_RES, REQ, CIN, DMODE, ACR, AVR;
  logic [3:0] OP;
  logic [1:0] BSRC, DST;
  wire  [22:0] a_o;
  wire  [22:0] b_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PHI0 = ~PHI0;

  alu_op_sequencer #(.DEC_EN(1)) u0 (
    .PHI0(PHI0), .n_RES(n_RES), .REQ(REQ), .OP(OP), .BSRC(BSRC), .DST(DST),
    .CIN(CIN), .DMODE(DMODE), .ACR(ACR), .AVR(AVR),
    .BUSY(a_o[I_BUSY]), .DONE(a_o[I_DONE]), .ERR(a_o[I_ERR]),
    .C_OUT(a_o[I_C]), .V_OUT(a_o[I_V]),
    .SB_ADD(a_o[I_SBADD]), .NDB_ADD(a_o[I_NDB]), .DB_ADD(a_o[I_DB]),
    .Z_ADD(a_o[I_Z]), .ADL_ADD(a_o[I_ADL]),
    .ANDS(a_o[I_ANDS]), .EORS(a_o[I_EORS]), .ORS(a_o[I_ORS]),
    .SRS(a_o[I_SRS]), .SUMS(a_o[I_SUMS]),
    .ADD_SB06(a_o[I_SB06]), .ADD_SB7(a_o[I_SB7]), .ADD_ADL(a_o[I_ADDADL]),
    .SB_AC(a_o[I_SBAC]), .AC_SB(a_o[I_ACSB]),
    .n_ACIN(a_o[I_NACIN]), .n_DAA(a_o[I_NDAA]), .n_DSA(a_o[I_NDSA])
  );

  alu_op_sequencer #(.DEC_EN(0)) u1 (
    .PHI0(PHI0), .n_RES(n_RES), .REQ(REQ), .OP(OP), .BSRC(BSRC), .DST(DST),
    .CIN(CIN), .DMODE(DMODE), .ACR(ACR), .AVR(AVR),
    .BUSY(b_o[I_BUSY]), .DONE(b_o[I_DONE]), .ERR(b_o[I_ERR]),
    .C_OUT(b_o[I_C]), .V_OUT(b_o[I_V]),
    .SB_ADD(b_o[I_SBADD]), .NDB_ADD(b_o[I_NDB]), .DB_ADD(b_o[I_DB]),
    .Z_ADD(b_o[I_Z]), .ADL_ADD(b_o[I_ADL]),
    .ANDS(b_o[I_ANDS]), .EORS(b_o[I_EORS]), .ORS(b_o[I_ORS]),
    .SRS(b_o[I_SRS]), .SUMS(b_o[I_SUMS]),
    .ADD_SB06(b_o[I_SB06]), .ADD_SB7(b_o[I_SB7]), .ADD_ADL(b_o[I_ADDADL]),
    .SB_AC(b_o[I_SBAC]), .AC_SB(b_o[I_ACSB]),
    .n_ACIN(b_o[I_NACIN]), .n_DAA(b_o[I_NDAA]), .n_DSA(b_o[I_NDSA])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 operate, 3 write-back.
  int         m_ph = 0;
  logic [3:0] m_op = 4'd0;
  logic [1:0] m_bs = 2'd0, m_ds = 2'd0;
  logic       m_cin = 1'b0, m_dm = 1'b0, m_c = 1'b0, m_v = 1'b0;

  always @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      m_ph <= 0;
      m_c  <= 1'b0;
      m_v  <= 1'b0;
    end else begin
      if ((m_ph == 0 || m_ph == 3) && REQ) begin
        m_op <= OP; m_bs <= BSRC; m_ds <= DST; m_cin <= CIN; m_dm <= DMODE;
        m_ph <= 1;
      end else if (m_ph == 3 || m_ph == 0) begin
        m_ph <= 0;
      end else begin
        m_ph <= m_ph + 1;
      end
      if (m_ph == 2) begin
        if (m_op inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8}) m_c <= ACR;
        if (m_op inside {4'd0, 4'd1}) m_v <= AVR;
      end
    end
  end

  function automatic logic [22:0] exp_vec(input int ph, input logic [3:0] op,
      input logic [1:0] bs, input logic [1:0] ds, input logic cin, input logic dm,
      input logic dec, input logic c, input logic v);
    logic [22:0] e;
    logic legal, ld, opr, wb, wr, dec_ph;
    logic [1:0] sel;
    e      = '0;
    legal  = (op <= 4'd8);
    ld     = (ph == 1);
    opr    = (ph == 2) && legal;
    wb     = (ph == 3);
    wr     = wb && legal && (op != 4'd6);
    dec_ph = (ph == 2) || (ph == 3);
    sel    = bs;
    if (op == 4'd1 || op == 4'd6) sel = 2'd1;
    if (op == 4'd8) sel = 2'd3;
    e[I_BUSY]   = (ph != 0);
    e[I_DONE]   = wb;
    e[I_ERR]    = wb && !legal;
    e[I_C]      = c;
    e[I_V]      = v;
    e[I_SBADD]  = ld && (op != 4'd5);
    e[I_DB]     = ld && (sel == 2'd0);
    e[I_NDB]    = ld && (sel == 2'd1);
    e[I_Z]      = ld && ((sel == 2'd2) || (op == 4'd5));
    e[I_ADL]    = ld && (sel == 2'd3);
    e[I_ACSB]   = ld && legal;
    e[I_SUMS]   = opr && (op inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8});
    e[I_ANDS]   = opr && (op == 4'd2);
    e[I_ORS]    = opr && (op == 4'd3);
    e[I_EORS]   = opr && (op == 4'd4);
    e[I_SRS]    = opr && (op == 4'd5);
    e[I_SB06]   = wr && (ds == 2'd1 || ds == 2'd3);
    e[I_SB7]    = wr && (ds == 2'd1 || ds == 2'd3);
    e[I_ADDADL] = wr && (ds == 2'd2);
    e[I_SBAC]   = wr && (ds == 2'd1);
    e[I_NACIN]  = opr ? ~((op == 4'd6) ? 1'b1 : cin) : 1'b1;
    e[I_NDAA]   = !(dec_ph && op == 4'd0 && dm && dec);
    e[I_NDSA]   = !(dec_ph && op == 4'd1 && dm && dec);
    return e;
  endfunction

  // Per-cycle compare against the model plus the structural invariants.
  always @(negedge PHI0) begin
    int nb, no;
    chk("model_dec1", a_o, exp_vec(m_ph, m_op, m_bs, m_ds, m_cin, m_dm, 1'b1, m_c, m_v));
    chk("model_dec0", b_o, exp_vec(m_ph, m_op, m_bs, m_ds, m_cin, m_dm, 1'b0, m_c, m_v));
    nb = a_o[I_DB] + a_o[I_NDB] + a_o[I_ADL] + (a_o[I_Z] && a_o[I_SBADD]);
    no = a_o[I_ANDS] + a_o[I_EORS] + a_o[I_ORS] + a_o[I_SRS] + a_o[I_SUMS];
    chk("inv_one_b", (nb <= 1), 1);
    chk("inv_one_op", (no <= 1), 1);
    chk("inv_dec_lines", (!a_o[I_NDAA] && !a_o[I_NDSA]), 0);
    chk("inv_sbac_acsb", (a_o[I_SBAC] && a_o[I_ACSB]), 0);
  end

  task automatic tick();
    @(posedge PHI0);
    #1;
  endtask

  // Presents a request, lets it be accepted, then scrambles the inputs.
  task automatic issue(input logic [3:0] op, input logic [1:0] bs, input logic [1:0] ds,
                       input logic cin, input logic dm, input logic acr, input logic avr);
    OP = op; BSRC = bs; DST = ds; CIN = cin; DMODE = dm; ACR = acr; AVR = avr;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    OP = op ^ 4'h5; BSRC = ~bs; DST = ~ds; CIN = ~cin; DMODE = ~dm;
  endtask

  logic [5:0] done_v, busy_v;

  initial begin
    n_RES = 1'b0; REQ = 1'b0; OP = '0; BSRC = '0; DST = '0;
    CIN = 1'b0; DMODE = 1'b0; ACR = 1'b0; AVR = 1'b0;
    tick();
    tick();
    chk("rst_vec", a_o, 23'h000007);
    n_RES = 1'b1;
    tick();

    // SBC, decimal mode, BSRC=DB still routes NDB
    issue(4'd1, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sbc_ndb", {a_o[I_NDB], a_o[I_DB]}, 2'b10);
    tick();
    chk("sbc_dsa_oper", {a_o[I_NDAA], a_o[I_NDSA]}, 2'b10);
    chk("sbc_dsa_nodec", b_o[I_NDSA], 1);
    tick();
    chk("sbc_dsa_wrbk", {a_o[I_NDSA], a_o[I_DONE]}, 2'b01);
    tick();

    // ADC DB->AC, carry in
    issue(4'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("adc_load", {a_o[I_ACSB], a_o[I_SBADD], a_o[I_DB]}, 3'b111);
    tick();
    chk("adc_oper", {a_o[I_SUMS], a_o[I_NACIN]}, 2'b10);
    tick();
    chk("adc_wrbk", {a_o[I_SBAC], a_o[I_SB06], a_o[I_SB7], a_o[I_DONE]}, 4'b1111);
    tick();
    chk("adc_flags", {a_o[I_C], a_o[I_V], a_o[I_BUSY]}, 3'b110);

    // CMP: forced carry, no transfers, V held
    issue(4'd6, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("cmp_acin", a_o[I_NACIN], 0);
    tick();
    chk("cmp_wrbk", {a_o[I_SBAC], a_o[I_SB06], a_o[I_SB7], a_o[I_DONE]}, 4'b0001);
    tick();
    chk("cmp_flags", {a_o[I_C], a_o[I_V]}, 2'b01);

    // Back-to-back AND then ORA with REQ held
    OP = 4'd2; BSRC = 2'd1; DST = 2'd1; CIN = 1'b0; DMODE = 1'b0; ACR = 1'b1; AVR = 1'b0;
    REQ = 1'b1;
    tick();
    OP = 4'd3; BSRC = 2'd0; DST = 2'd2;
    for (int k = 0; k < 6; k++) begin
      done_v[k] = a_o[I_DONE];
      busy_v[k] = a_o[I_BUSY];
      if (k == 3) begin
        chk("b2b_load2", a_o[I_ACSB], 1);
        REQ = 1'b0;
      end
      tick();
    end
    chk("b2b_done", done_v, 6'b100100);
    chk("b2b_busy", busy_v, 6'b111111);
    chk("b2b_idle_flags", {a_o[I_BUSY], a_o[I_C], a_o[I_V]}, 3'b001);

    // Illegal opcode 12
    issue(4'd12, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("ill_load_acsb", a_o[I_ACSB], 0);
    tick();
    chk("ill_ops", a_o[I_ANDS:I_SUMS], 0);
    tick();
    chk("ill_wrbk", {a_o[I_DONE], a_o[I_ERR], a_o[I_SBAC], a_o[I_SB06]}, 4'b1100);
    tick();
    chk("ill_flags", {a_o[I_C], a_o[I_V]}, 2'b01);

    // Shift right: Z on A side, B from BSRC, SB-only write-back
    issue(4'd5, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sr_load", {a_o[I_SBADD], a_o[I_Z], a_o[I_DB], a_o[I_ACSB]}, 4'b0111);
    tick();
    chk("sr_oper", {a_o[I_SRS], a_o[I_NACIN]}, 2'b10);
    tick();
    chk("sr_wrbk", {a_o[I_SB06], a_o[I_SB7], a_o[I_SBAC]}, 3'b110);
    tick();
    chk("sr_flags", {a_o[I_C], a_o[I_V]}, 2'b11);

    // Remaining ops, checked by the per-cycle model
    issue(4'd8, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();
    issue(4'd7, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick(); tick(); tick();
    issue(4'd4, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0); tick(); tick(); tick();
    issue(4'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("adc_daa", {a_o[I_NDAA], b_o[I_NDAA]}, 2'b01);
    tick(); tick();
    issue(4'd15, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1); tick(); tick(); tick();

    // Asynchronous reset in the middle of OPER
    issue(4'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("mid_oper_sums", a_o[I_SUMS], 1);
    #2;
    n_RES = 1'b0;
    #1;
    chk("mid_rst_vec", a_o, 23'h000007);
    chk("mid_rst_vec_b", b_o, 23'h000007);
    tick();
    n_RES = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
